// File: rtl/ysyx_24080034_ifu_if.sv
// Fetch-unit bus: instruction-memory request/response, decode handoff and redirect.
// The master side is the IFU; the slave side is memory + decode + branch logic.
interface ysyx_24080034_ifu_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  modport master (
    output imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready,
           redirect_valid, redirect_pc
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready,
           redirect_valid, redirect_pc
  );
endinterface

// File: rtl/ysyx_24080034_ifu.sv
// Single-outstanding instruction fetch unit: one fetch in flight, one instruction
// held for decode, redirects override the PC and squash any stale fetch.
module ysyx_24080034_ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic                       clk,
  input  logic                       rst,
  ysyx_24080034_ifu_if.master        bus
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] inst_q;
  logic [31:0] inst_pc_q;
  logic        kill_q;

  logic [31:0] redir_pc;
  logic        req_fire;
  logic        inst_fire;

  assign redir_pc  = bus.redirect_pc & 32'hFFFF_FFFC;

  // A redirect masks both handshakes in the cycle it arrives.
  assign bus.imem_req_valid = (state_q == S_REQ)  && !bus.redirect_valid;
  assign bus.inst_valid     = (state_q == S_HOLD) && !bus.redirect_valid;
  assign bus.imem_req_addr  = (state_q == S_IDLE) ? 32'h0 : pc_q;
  assign bus.inst           = inst_q;
  assign bus.inst_pc        = inst_pc_q;

  assign req_fire  = bus.imem_req_valid && bus.imem_req_ready;
  assign inst_fire = bus.inst_valid && bus.inst_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_PC;
      inst_q    <= 32'h0;
      inst_pc_q <= 32'h0;
      kill_q    <= 1'b0;
    end else begin
      if (bus.redirect_valid) pc_q <= redir_pc;
      unique case (state_q)
        S_IDLE: state_q <= S_REQ;
        S_REQ:  if (req_fire) state_q <= S_WAIT;
        S_WAIT: begin
          // A response racing a redirect belongs to the old path and is dropped.
          if (bus.imem_rsp_valid) begin
            if (kill_q || bus.redirect_valid) begin
              kill_q  <= 1'b0;
              state_q <= S_REQ;
            end else begin
              inst_q    <= bus.imem_rsp_data;
              inst_pc_q <= pc_q;
              state_q   <= S_HOLD;
            end
          end else if (bus.redirect_valid) begin
            kill_q <= 1'b1;
          end
        end
        S_HOLD: begin
          if (bus.redirect_valid) begin
            state_q <= S_REQ;
          end else if (inst_fire) begin
            pc_q    <= pc_q + 32'd4;
            state_q <= S_REQ;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_24080034_ifu.sv
// Bench for the fetch unit: a latency-programmable memory responder plus a
// transaction-level model of which PC is fetched next and which word decode sees.
module tb_ysyx_24080034_ifu;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ysyx_24080034_ifu_if bus();
  ysyx_24080034_ifu #(.RESET_PC(32'h8000_0000)) dut (.clk(clk), .rst(rst), .bus(bus));

  int nchk = 0;
  int nerr = 0;

  // memory responder state (reacts to the real bus)
  bit          mpend;
  int          mcnt;
  logic [31:0] maddr;
  int          lat = 2;

  // reference model: next fetch address, outstanding fetch, instruction on offer
  bit          m_idle, m_out, m_stale, m_avail;
  logic [31:0] m_addr, m_out_pc, m_av_pc;

  // observations for directed checks
  logic [31:0] last_req_addr, last_inst, last_inst_pc;
  logic        last_iv;
  int          seen_iv;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h8000_0000) return 32'hFFF0_0093;
    if (a == 32'h8000_0004) return 32'h0000_0013;
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic model_reset();
    m_idle = 1; m_out = 0; m_stale = 0; m_avail = 0;
    m_addr = 32'h8000_0000; m_out_pc = 0; m_av_pc = 0;
    mpend = 0; mcnt = 0; maddr = 0;
  endtask

  task automatic drive_idle();
    bus.imem_req_ready = 0; bus.imem_rsp_valid = 0; bus.imem_rsp_data = 0;
    bus.inst_ready = 0; bus.redirect_valid = 0; bus.redirect_pc = 0;
  endtask

  // One clock cycle; entered just after a falling edge.
  task automatic step(input bit redir, input logic [31:0] rpc, input bit rdy, input bit irdy);
    bit rsp, exp_req, exp_iv;
    rsp = mpend && (mcnt == 0);
    bus.redirect_valid = redir;  bus.redirect_pc = rpc;
    bus.imem_req_ready = rdy;    bus.inst_ready  = irdy;
    bus.imem_rsp_valid = rsp;    bus.imem_rsp_data = rsp ? mem_word(maddr) : $urandom;
    #1;
    exp_req = !m_idle && !m_out && !m_avail && !redir;
    exp_iv  = m_avail && !redir;
    nchk++;
    if (bus.imem_req_valid !== exp_req) begin
      nerr++; $display("FAIL req_valid t=%0t got=%b exp=%b", $time, bus.imem_req_valid, exp_req);
    end
    if (exp_req) begin
      nchk++;
      if (bus.imem_req_addr !== m_addr) begin
        nerr++; $display("FAIL req_addr t=%0t got=%h exp=%h", $time, bus.imem_req_addr, m_addr);
      end
    end
    nchk++;
    if (bus.inst_valid !== exp_iv) begin
      nerr++; $display("FAIL inst_valid t=%0t got=%b exp=%b", $time, bus.inst_valid, exp_iv);
    end
    if (exp_iv) begin
      nchk++;
      if (bus.inst_pc !== m_av_pc || bus.inst !== mem_word(m_av_pc)) begin
        nerr++; $display("FAIL inst_data t=%0t got=%h@%h exp=%h@%h", $time,
                         bus.inst, bus.inst_pc, mem_word(m_av_pc), m_av_pc);
      end
    end
    last_iv = bus.inst_valid;
    if (bus.imem_req_valid === 1'b1) last_req_addr = bus.imem_req_addr;
    if (bus.inst_valid === 1'b1) begin
      seen_iv++; last_inst = bus.inst; last_inst_pc = bus.inst_pc;
    end
    if (rsp) mpend = 0;
    else if (mpend) mcnt--;
    if (bus.imem_req_valid === 1'b1 && rdy) begin
      mpend = 1; mcnt = lat - 1; maddr = bus.imem_req_addr;
    end
    m_idle = 0;
    if (redir) begin
      m_addr = rpc & 32'hFFFF_FFFC; m_stale = m_stale | m_out; m_avail = 0;
    end else if (exp_req && rdy) begin
      m_out = 1; m_stale = 0; m_out_pc = m_addr;
    end else if (exp_iv && irdy) begin
      m_avail = 0; m_addr = m_av_pc + 32'd4;
    end
    if (rsp && m_out) begin
      m_out = 0;
      if (!m_stale) begin m_avail = 1; m_av_pc = m_out_pc; end
      m_stale = 0;
    end
    @(posedge clk); @(negedge clk);
  endtask

  task automatic wait_avail(input string tag);
    int n = 0;
    while (!m_avail && n < 20) begin step(0, 0, 0, 0); n++; end
    nchk++;
    if (!m_avail) begin nerr++; $display("FAIL %s_timeout got=no_inst exp=inst", tag); end
  endtask

  task automatic check_outputs_zero(input string tag);
    logic [97:0] outs;
    outs = {bus.imem_req_valid, bus.imem_req_addr, bus.inst_valid, bus.inst, bus.inst_pc};
    nchk++;
    if (outs !== 98'h0) begin nerr++; $display("FAIL %s got=%h exp=0", tag, outs); end
  endtask

  task automatic test_reset();
    rst = 1; drive_idle(); model_reset();
    repeat (3) begin @(negedge clk); #1; check_outputs_zero("reset_outputs"); end
    rst = 0;
    step(0, 0, 0, 0);
    last_req_addr = 'x;
    step(0, 0, 0, 0);
    nchk++;
    if (last_req_addr !== 32'h8000_0000) begin
      nerr++; $display("FAIL first_req_addr got=%h exp=80000000", last_req_addr);
    end
  endtask

  task automatic test_basic_fetch();
    int k = 0;
    lat = 2; seen_iv = 0;
    step(0, 0, 1, 0);
    while (seen_iv == 0 && k < 10) begin step(0, 0, 0, 0); k++; end
    nchk++;
    if (k != 3) begin nerr++; $display("FAIL fetch_latency got=%0d exp=3", k); end
    step(0, 0, 0, 0); step(0, 0, 0, 0);
    nchk++;
    if (last_inst !== 32'hFFF0_0093 || last_inst_pc !== 32'h8000_0000) begin
      nerr++; $display("FAIL held_inst got=%h@%h exp=fff00093@80000000", last_inst, last_inst_pc);
    end
    step(0, 0, 0, 1);
    last_req_addr = 'x;
    step(0, 0, 0, 0);
    nchk++;
    if (last_req_addr !== 32'h8000_0004) begin
      nerr++; $display("FAIL next_seq_addr got=%h exp=80000004", last_req_addr);
    end
  endtask

  task automatic test_kill_in_wait();
    lat = 2;
    step(0, 0, 1, 0);
    step(1, 32'h8000_0100, 0, 0);
    seen_iv = 0; last_req_addr = 'x;
    repeat (3) step(0, 0, 0, 0);
    nchk++;
    if (seen_iv != 0) begin nerr++; $display("FAIL killed_inst got=%0d_valid exp=0", seen_iv); end
    nchk++;
    if (last_req_addr !== 32'h8000_0100) begin
      nerr++; $display("FAIL kill_redirect_addr got=%h exp=80000100", last_req_addr);
    end
  endtask

  task automatic test_hold_redirect();
    lat = 1;
    step(0, 0, 1, 0);
    wait_avail("hold");
    step(1, 32'h8000_0200, 0, 1);
    nchk++;
    if (last_iv !== 1'b0) begin nerr++; $display("FAIL hold_drop got=%b exp=0", last_iv); end
    last_req_addr = 'x;
    step(0, 0, 0, 0);
    nchk++;
    if (last_req_addr !== 32'h8000_0200) begin
      nerr++; $display("FAIL hold_redirect_addr got=%h exp=80000200", last_req_addr);
    end
  endtask

  task automatic test_wrap();
    lat = 3;
    step(1, 32'hFFFF_FFFF, 0, 0);
    last_req_addr = 'x;
    step(0, 0, 1, 0);
    nchk++;
    if (last_req_addr !== 32'hFFFF_FFFC) begin
      nerr++; $display("FAIL wrap_req_addr got=%h exp=fffffffc", last_req_addr);
    end
    wait_avail("wrap");
    step(0, 0, 0, 1);
    last_req_addr = 'x;
    step(0, 0, 0, 0);
    nchk++;
    if (last_req_addr !== 32'h0000_0000) begin
      nerr++; $display("FAIL wrap_next_addr got=%h exp=00000000", last_req_addr);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      lat = $urandom_range(1, 4);
      step(($urandom_range(0, 7) == 0), $urandom, $urandom_range(0, 1), $urandom_range(0, 1));
    end
  endtask

  task automatic test_reset_mid_wait();
    int n = 0;
    lat = 3;
    while (!(m_out && !m_stale) && n < 50) begin step(0, 0, 1, 1); n++; end
    nchk++;
    if (!(m_out && !m_stale)) begin nerr++; $display("FAIL reach_wait got=no_fetch exp=fetch"); end
    drive_idle();
    #2 rst = 1;
    #1 check_outputs_zero("async_reset");
    @(negedge clk);
    bus.imem_rsp_valid = 1; bus.imem_rsp_data = $urandom;
    @(negedge clk);
    bus.imem_rsp_valid = 0;
    #1 check_outputs_zero("reset_ignores_rsp");
    @(negedge clk);
    rst = 0; model_reset(); lat = 2;
    step(0, 0, 0, 0);
    last_req_addr = 'x;
    step(0, 0, 1, 0);
    nchk++;
    if (last_req_addr !== 32'h8000_0000) begin
      nerr++; $display("FAIL restart_addr got=%h exp=80000000", last_req_addr);
    end
    wait_avail("restart");
    step(0, 0, 0, 0);
    nchk++;
    if (last_inst !== 32'hFFF0_0093) begin
      nerr++; $display("FAIL restart_inst got=%h exp=fff00093", last_inst);
    end
  endtask

  initial begin
    test_reset();
    test_basic_fetch();
    test_kill_in_wait();
    test_hold_redirect();
    test_wrap();
    test_random();
    test_reset_mid_wait();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
